// File: rtl/prim_onehot_check_mc.sv
// Multi-channel onehot checker: per-channel onehot/enable/address checks with
// registered error pulses, sticky flags, saturating error counter, first-error capture and fatal escalation.
module prim_onehot_check_mc #(
  parameter int AddrWidth    = 5,
  parameter int OneHotWidth  = 2**AddrWidth,
  parameter int NumChan      = 4,
  parameter bit AddrCheck    = 1'b1,
  parameter bit EnableCheck  = 1'b1,
  parameter bit StrictCheck  = 1'b1,
  parameter int CntWidth     = 8,
  parameter int ErrThreshold = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [NumChan-1:0]                           valid_i,
  input  logic [NumChan*OneHotWidth-1:0]               oh_i,
  input  logic [NumChan*AddrWidth-1:0]                 addr_i,
  input  logic [NumChan-1:0]                           en_i,
  input  logic                                         clr_i,
  output logic [NumChan-1:0]                           err_o,
  output logic [NumChan-1:0]                           err_sticky_o,
  output logic [CntWidth-1:0]                          err_cnt_o,
  output logic [((NumChan > 1) ? $clog2(NumChan) : 1)-1:0] first_chan_o,
  output logic [2:0]                                   first_type_o,
  output logic                                         fatal_o
);

  localparam int ChanW = (NumChan > 1) ? $clog2(NumChan) : 1;
  localparam int Lvls  = $clog2(OneHotWidth);
  localparam int PadW  = 1 << Lvls;
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_ERR   = 2'd1,
    ST_FATAL = 2'd2
  } state_t;

  logic [NumChan-1:0][2:0] chan_flags;
  logic [NumChan-1:0]      chan_err;
  logic                    any_err;

  genvar gc, gl, gi;
  generate
    for (gc = 0; gc < NumChan; gc++) begin : g_chan
      logic [OneHotWidth-1:0] oh;
      logic [AddrWidth-1:0]   addr;
      logic                   en;
      logic                   oh_any, oh_multi, oh_sel;
      logic                   oh0_err, en_err, addr_err;

      assign oh   = oh_i[gc*OneHotWidth +: OneHotWidth];
      assign addr = addr_i[gc*AddrWidth +: AddrWidth];
      assign en   = en_i[gc];

      // Each tree node carries: any bit set, more than one bit set, addressed bit set.
      for (gl = 0; gl <= Lvls; gl++) begin : g_lvl
        localparam int N = PadW >> gl;
        logic [N-1:0] any_v, multi_v, sel_v;
        if (gl == 0) begin : g_leaf
          for (gi = 0; gi < PadW; gi++) begin : g_bit
            if (gi < OneHotWidth) begin : g_real
              assign any_v[gi]   = oh[gi];
              assign multi_v[gi] = 1'b0;
              assign sel_v[gi]   = oh[gi] & (addr == AddrWidth'(gi));
            end else begin : g_pad
              assign any_v[gi]   = 1'b0;
              assign multi_v[gi] = 1'b0;
              assign sel_v[gi]   = 1'b0;
            end
          end
        end else begin : g_node
          for (gi = 0; gi < N; gi++) begin : g_bit
            assign any_v[gi]   = g_lvl[gl-1].any_v[2*gi] | g_lvl[gl-1].any_v[2*gi+1];
            assign multi_v[gi] = g_lvl[gl-1].multi_v[2*gi] | g_lvl[gl-1].multi_v[2*gi+1] |
                                 (g_lvl[gl-1].any_v[2*gi] & g_lvl[gl-1].any_v[2*gi+1]);
            assign sel_v[gi]   = g_lvl[gl-1].sel_v[2*gi] | g_lvl[gl-1].sel_v[2*gi+1];
          end
        end
      end

      assign oh_any   = g_lvl[Lvls].any_v[0];
      assign oh_multi = g_lvl[Lvls].multi_v[0];
      assign oh_sel   = g_lvl[Lvls].sel_v[0];

      assign oh0_err  = oh_multi;
      assign en_err   = EnableCheck ? (StrictCheck ? (oh_any != en) : (!en && oh_any)) : 1'b0;
      assign addr_err = AddrCheck ? (oh_sel != oh_any) : 1'b0;

      assign chan_flags[gc] = valid_i[gc] ? {addr_err, en_err, oh0_err} : 3'b000;
      assign chan_err[gc]   = |chan_flags[gc];
    end
  endgenerate

  assign any_err = |chan_err;

  logic [NumChan-1:0]  err_reg, sticky_reg, sticky_next;
  logic [CntWidth-1:0] cnt_reg, cnt_base, cnt_next;
  logic [ChanW-1:0]    first_chan_reg, first_chan_next, first_idx;
  logic [2:0]          first_type_reg, first_type_next;
  logic                cap_valid_reg, cap_valid_next;
  state_t              state_reg, state_next;

  // Clear is applied before the current cycle's errors are folded in.
  always_comb begin
    first_idx = '0;
    for (int c = NumChan - 1; c >= 0; c--) begin
      if (chan_err[c]) first_idx = ChanW'(c);
    end

    cnt_base = clr_i ? '0 : cnt_reg;
    cnt_next = cnt_base;
    if (any_err && (cnt_base != CntMax)) cnt_next = cnt_base + CntWidth'(1);

    sticky_next = (clr_i ? '0 : sticky_reg) | chan_err;

    first_chan_next = first_chan_reg;
    first_type_next = first_type_reg;
    cap_valid_next  = cap_valid_reg;
    if (clr_i) begin
      first_chan_next = '0;
      first_type_next = '0;
      cap_valid_next  = 1'b0;
    end
    if (any_err && (!cap_valid_reg || clr_i)) begin
      first_chan_next = first_idx;
      first_type_next = chan_flags[first_idx];
      cap_valid_next  = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OK, ST_ERR: begin
        if (cnt_next >= CntWidth'(ErrThreshold)) state_next = ST_FATAL;
        else if (any_err)                         state_next = ST_ERR;
        else if (clr_i)                           state_next = ST_OK;
      end
      ST_FATAL: state_next = ST_FATAL;
      default:  state_next = ST_OK;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_OK;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_reg        <= '0;
      sticky_reg     <= '0;
      cnt_reg        <= '0;
      first_chan_reg <= '0;
      first_type_reg <= '0;
      cap_valid_reg  <= 1'b0;
    end else begin
      err_reg        <= chan_err;
      sticky_reg     <= sticky_next;
      cnt_reg        <= cnt_next;
      first_chan_reg <= first_chan_next;
      first_type_reg <= first_type_next;
      cap_valid_reg  <= cap_valid_next;
    end
  end

  assign err_o        = err_reg;
  assign err_sticky_o = sticky_reg;
  assign err_cnt_o    = cnt_reg;
  assign first_chan_o = first_chan_reg;
  assign first_type_o = first_type_reg;
  assign fatal_o      = (state_reg == ST_FATAL);

endmodule

// File: tb/tb_prim_onehot_check_mc.sv
// Directed bench for prim_onehot_check_mc: default, non-strict and narrow-counter instances
// share the same stimulus; each step checks registered outputs 1 time unit after the edge.
module tb_prim_onehot_check_mc;

  logic         clk;
  logic         rst;
  logic [3:0]   valid;
  logic [127:0] oh;
  logic [19:0]  addr;
  logic [3:0]   en;
  logic         clr;

  logic [3:0] err, sticky;
  logic [7:0] cnt;
  logic [1:0] fchan;
  logic [2:0] ftype;
  logic       fatal;

  logic [3:0] ns_err, ns_sticky;
  logic [7:0] ns_cnt;
  logic [1:0] ns_fchan;
  logic [2:0] ns_ftype;
  logic       ns_fatal;

  logic [3:0] sat_err, sat_sticky;
  logic [1:0] sat_cnt;
  logic [1:0] sat_fchan;
  logic [2:0] sat_ftype;
  logic       sat_fatal;

  int n_checks = 0;
  int n_errors = 0;

  prim_onehot_check_mc u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .oh_i(oh), .addr_i(addr), .en_i(en), .clr_i(clr),
    .err_o(err), .err_sticky_o(sticky), .err_cnt_o(cnt), .first_chan_o(fchan),
    .first_type_o(ftype), .fatal_o(fatal)
  );

  prim_onehot_check_mc #(.StrictCheck(1'b0)) u_dut_ns (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .oh_i(oh), .addr_i(addr), .en_i(en), .clr_i(clr),
    .err_o(ns_err), .err_sticky_o(ns_sticky), .err_cnt_o(ns_cnt), .first_chan_o(ns_fchan),
    .first_type_o(ns_ftype), .fatal_o(ns_fatal)
  );

  prim_onehot_check_mc #(.CntWidth(2), .ErrThreshold(3)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .oh_i(oh), .addr_i(addr), .en_i(en), .clr_i(clr),
    .err_o(sat_err), .err_sticky_o(sat_sticky), .err_cnt_o(sat_cnt), .first_chan_o(sat_fchan),
    .first_type_o(sat_ftype), .fatal_o(sat_fatal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic idle();
    valid = '0;
    oh    = '0;
    addr  = '0;
    en    = '0;
    clr   = 1'b0;
  endtask

  task automatic chan(input int c, input logic [31:0] o, input logic [4:0] a, input logic e);
    valid[c]       = 1'b1;
    oh[c*32 +: 32] = o;
    addr[c*5 +: 5] = a;
    en[c]          = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_cnt   [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  logic       exp_fatal [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] exp_scnt  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic       exp_sfat  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_err", err, 4'h0);
    check("rst_sticky", sticky, 4'h0);
    check("rst_cnt", cnt, 8'd0);
    check("rst_fchan", fchan, 2'd0);
    check("rst_ftype", ftype, 3'b000);
    check("rst_fatal", fatal, 1'b0);
    check("rst_sat_cnt", sat_cnt, 2'd0);

    // Address check: matching and mismatching index on channel 2.
    rst = 1'b0;
    idle(); chan(2, 32'h0000_0010, 5'd4, 1'b1); step();
    check("addr_ok_err", err, 4'b0000);
    check("addr_ok_cnt", cnt, 8'd0);
    idle(); chan(2, 32'h0000_0010, 5'd5, 1'b1); step();
    check("addr_bad_err", err, 4'b0100);
    check("addr_bad_ftype", ftype, 3'b100);
    check("addr_bad_fchan", fchan, 2'd2);
    check("addr_bad_cnt", cnt, 8'd1);
    check("addr_bad_sticky", sticky, 4'b0100);
    idle(); clr = 1'b1; step();
    check("clr_cnt", cnt, 8'd0);
    check("clr_sticky", sticky, 4'b0000);
    check("clr_ftype", ftype, 3'b000);
    check("clr_err", err, 4'b0000);

    // Two channels erroring in the same cycle.
    idle(); chan(0, 32'h0000_0003, 5'd0, 1'b1); chan(3, 32'h0, 5'd0, 1'b1); step();
    check("two_err", err, 4'b1001);
    check("two_fchan", fchan, 2'd0);
    check("two_ftype", ftype, 3'b001);
    check("two_cnt", cnt, 8'd1);
    check("two_sticky", sticky, 4'b1001);
    check("two_ns_err", ns_err, 4'b0001);
    idle(); step();
    check("hold_err", err, 4'b0000);
    check("hold_sticky", sticky, 4'b1001);
    check("hold_fchan", fchan, 2'd0);
    check("hold_cnt", cnt, 8'd1);

    // Strict vs non-strict enable checking, with clr held so counters stay low.
    idle(); clr = 1'b1; chan(0, 32'h0, 5'd0, 1'b1); step();
    check("en1_oh0_ns_err", ns_err, 4'b0000);
    check("en1_oh0_st_err", err, 4'b0001);
    idle(); clr = 1'b1; chan(0, 32'h1, 5'd0, 1'b0); step();
    check("en0_oh1_ns_err", ns_err, 4'b0001);
    check("en0_oh1_st_err", err, 4'b0001);
    idle(); clr = 1'b1; oh = {128{1'b1}}; step();
    check("invalid_ns_err", ns_err, 4'b0000);
    check("invalid_st_err", err, 4'b0000);
    idle(); clr = 1'b1; valid = 4'hF; step();
    check("zero_en0_err", err, 4'b0000);
    check("zero_en0_cnt", cnt, 8'd0);
    check("zero_en0_sat_cnt", sat_cnt, 2'd0);
    check("zero_en0_sat_fatal", sat_fatal, 1'b0);

    // Five consecutive error cycles: threshold escalation and saturation.
    for (int i = 0; i < 5; i++) begin
      idle(); chan(1, 32'h0000_0003, 5'd0, 1'b1); step();
      check($sformatf("run%0d_err", i), err, 4'b0010);
      check($sformatf("run%0d_cnt", i), cnt, exp_cnt[i]);
      check($sformatf("run%0d_fatal", i), fatal, exp_fatal[i]);
      check($sformatf("run%0d_sat_cnt", i), sat_cnt, exp_scnt[i]);
      check($sformatf("run%0d_sat_fatal", i), sat_fatal, exp_sfat[i]);
    end
    idle(); clr = 1'b1; step();
    check("fclr_cnt", cnt, 8'd0);
    check("fclr_fatal", fatal, 1'b1);
    check("fclr_sticky", sticky, 4'b0000);
    check("fclr_sat_cnt", sat_cnt, 2'd0);
    check("fclr_sat_fatal", sat_fatal, 1'b1);
    idle(); chan(0, 32'h0000_0003, 5'd0, 1'b1); step();
    check("ferr_err", err, 4'b0001);
    check("ferr_cnt", cnt, 8'd1);
    check("ferr_fatal", fatal, 1'b1);
    check("ferr_sticky", sticky, 4'b0001);
    idle(); rst = 1'b1; chan(0, 32'h0000_0003, 5'd0, 1'b1); step();
    check("frst_err", err, 4'b0000);
    check("frst_sticky", sticky, 4'b0000);
    check("frst_cnt", cnt, 8'd0);
    check("frst_fatal", fatal, 1'b0);
    check("frst_fchan", fchan, 2'd0);
    check("frst_ftype", ftype, 3'b000);
    check("frst_sat_fatal", sat_fatal, 1'b0);

    // First sample after reset, then clear coinciding with a new error.
    rst = 1'b0;
    idle(); chan(3, 32'h0000_0001, 5'd0, 1'b0); step();
    check("post_rst_err", err, 4'b1000);
    check("post_rst_fchan", fchan, 2'd3);
    check("post_rst_ftype", ftype, 3'b010);
    check("post_rst_cnt", cnt, 8'd1);
    check("post_rst_ns_err", ns_err, 4'b1000);
    idle(); clr = 1'b1; chan(1, 32'h0000_0004, 5'd3, 1'b1); step();
    check("clrerr_cnt", cnt, 8'd1);
    check("clrerr_sticky", sticky, 4'b0010);
    check("clrerr_fchan", fchan, 2'd1);
    check("clrerr_ftype", ftype, 3'b100);
    check("clrerr_err", err, 4'b0010);
    check("clrerr_fatal", fatal, 1'b0);
    idle(); chan(2, 32'h0000_0003, 5'd0, 1'b1); step();
    check("held_err", err, 4'b0100);
    check("held_fchan", fchan, 2'd1);
    check("held_ftype", ftype, 3'b100);
    check("held_cnt", cnt, 8'd2);
    check("held_sticky", sticky, 4'b0110);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
